// File: rtl/m_ser_checker.sv
// PRBS stream checker: self-synchronises a local LFSR to the received bits,
// declares lock, then flags and counts bit errors for BER measurement.
module m_ser_checker #(
   parameter int                LFSR_W   = 3,
   parameter logic [LFSR_W-1:0] TAPS     = 3'b101,
   parameter int                LOCK_CNT = 8,
   parameter int                WIN      = 64,
   parameter int                ERR_LIM  = 8,
   parameter int                CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int                FILL_W    = $clog2(LFSR_W + 1);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(LFSR_W);
   localparam logic [7:0]        LOCK_LAST = 8'(LOCK_CNT - 1);
   localparam logic [15:0]       WIN_LAST  = 16'(WIN - 1);
   localparam logic [15:0]       ERR_LAST  = 16'(ERR_LIM - 1);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t            state_r;
   logic [LFSR_W-1:0] hist_r;
   logic [FILL_W-1:0] fill_cnt_r;
   logic [7:0]        match_cnt_r;
   logic [15:0]       win_pos_r;
   logic [15:0]       win_err_r;
   logic              locked_r;
   logic              bit_err_r;
   logic [CNT_W-1:0]  err_cnt_r;
   logic [CNT_W-1:0]  bit_cnt_r;

   logic pred_s;
   logic mis_s;
   logic hist_nz_s;
   logic err_sat_s;
   logic bit_sat_s;

   assign pred_s    = ^(hist_r & TAPS);
   assign mis_s     = (din != pred_s);
   assign hist_nz_s = |hist_r;
   assign err_sat_s = &err_cnt_r;
   assign bit_sat_s = &bit_cnt_r;

   // Hunt/lock state machine, local LFSR history, window and result counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= HUNT;
         hist_r      <= {LFSR_W{1'b0}};
         fill_cnt_r  <= {FILL_W{1'b0}};
         match_cnt_r <= 8'd0;
         win_pos_r   <= 16'd0;
         win_err_r   <= 16'd0;
         locked_r    <= 1'b0;
         bit_err_r   <= 1'b0;
         err_cnt_r   <= {CNT_W{1'b0}};
         bit_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         bit_err_r <= 1'b0;
         if (din_valid) begin
            case (state_r)
               HUNT: begin
                  hist_r <= {hist_r[LFSR_W-2:0], din};
                  if (fill_cnt_r != FILL_DONE) begin
                     fill_cnt_r <= fill_cnt_r + 1'b1;
                  end else if (!mis_s && hist_nz_s) begin
                     if (match_cnt_r == LOCK_LAST) begin
                        state_r     <= LOCKED;
                        locked_r    <= 1'b1;
                        match_cnt_r <= 8'd0;
                        win_pos_r   <= 16'd0;
                        win_err_r   <= 16'd0;
                     end else begin
                        match_cnt_r <= match_cnt_r + 8'd1;
                     end
                  end else begin
                     // An all-zero history predicts zeros forever, so it never counts as a match.
                     match_cnt_r <= 8'd0;
                  end
               end
               LOCKED: begin
                  hist_r    <= {hist_r[LFSR_W-2:0], pred_s};
                  bit_err_r <= mis_s;
                  if (mis_s && !err_sat_s) begin
                     err_cnt_r <= err_cnt_r + CNT_W'(1);
                  end
                  if (!bit_sat_s) begin
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
                  if (mis_s && (win_err_r == ERR_LAST)) begin
                     state_r     <= HUNT;
                     locked_r    <= 1'b0;
                     fill_cnt_r  <= {FILL_W{1'b0}};
                     match_cnt_r <= 8'd0;
                     win_pos_r   <= 16'd0;
                     win_err_r   <= 16'd0;
                  end else if (win_pos_r == WIN_LAST) begin
                     win_pos_r <= 16'd0;
                     win_err_r <= 16'd0;
                  end else begin
                     win_pos_r <= win_pos_r + 16'd1;
                     win_err_r <= win_err_r + {15'd0, mis_s};
                  end
               end
               default: begin
                  state_r <= HUNT;
               end
            endcase
         end
         // Placed last so a clear overrides a same-edge increment.
         if (clr_cnt) begin
            err_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
         end
      end
   end

   assign locked  = locked_r;
   assign bit_err = bit_err_r;
   assign err_cnt = err_cnt_r;
   assign bit_cnt = bit_cnt_r;

endmodule

// File: tb/tb_m_ser_checker.sv
// Self-checking bench for m_ser_checker: directed phases plus random stimulus,
// checked against a bit-history reference model; a CNT_W=4 instance covers saturation.
module tb_m_ser_checker;

   localparam int         W        = 3;
   localparam logic [2:0] TAPS_P   = 3'b101;
   localparam int         LOCK_CNT = 8;
   localparam int         WIN      = 64;
   localparam int         ERR_LIM  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        locked, bit_err, locked4, bit_err4;
   logic [15:0] err_cnt, bit_cnt;
   logic [3:0]  err_cnt4, bit_cnt4;

   m_ser_checker u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
   );

   m_ser_checker #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked4), .bit_err(bit_err4), .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   int pat[7] = '{0, 0, 1, 1, 1, 0, 1};
   int idx = 0;

   // Reference model: mh[k] is the bit k+1 positions in the past.
   int mh[W];
   int m_fill, m_match, m_wpos, m_werr;
   int m_lock, m_err;
   int m_ec, m_bc, m_ec4, m_bc4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_pred();
      int p = 0;
      logic [2:0] t = TAPS_P;
      for (int k = 0; k < W; k++) if (t[k]) p = p ^ mh[k];
      return p;
   endfunction

   task automatic m_push(input int b);
      for (int k = W - 1; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = b;
   endtask

   task automatic model_step(input int d, input int v, input int c, input int r);
      int p, e, nz;
      if (r != 0) begin
         for (int k = 0; k < W; k++) mh[k] = 0;
         m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
         m_lock = 0; m_err = 0; m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
         return;
      end
      m_err = 0;
      if (v != 0) begin
         p = m_pred();
         if (m_lock == 0) begin
            nz = 0;
            for (int k = 0; k < W; k++) nz = nz | mh[k];
            if (m_fill < W) m_fill++;
            else if (d == p && nz != 0) begin
               m_match++;
               if (m_match == LOCK_CNT) begin
                  m_lock = 1; m_match = 0; m_wpos = 0; m_werr = 0;
               end
            end else m_match = 0;
            m_push(d);
         end else begin
            e = (d != p) ? 1 : 0;
            m_err = e;
            if (e != 0 && m_ec < 65535) m_ec++;
            if (e != 0 && m_ec4 < 15) m_ec4++;
            if (m_bc < 65535) m_bc++;
            if (m_bc4 < 15) m_bc4++;
            m_werr += e;
            m_wpos++;
            if (m_werr >= ERR_LIM) begin
               m_lock = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
            end else if (m_wpos == WIN) begin
               m_wpos = 0; m_werr = 0;
            end
            m_push(p);
         end
      end
      if (c != 0) begin
         m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
      end
   endtask

   task automatic step(input int d, input int v, input int c, input int r);
      din = d[0]; din_valid = v[0]; clr_cnt = c[0]; rst = r[0];
      @(posedge clk);
      model_step(d, v, c, r);
      #1;
      chk("locked", {31'd0, locked}, m_lock);
      chk("bit_err", {31'd0, bit_err}, m_err);
      chk("err_cnt", {16'd0, err_cnt}, m_ec);
      chk("bit_cnt", {16'd0, bit_cnt}, m_bc);
      chk("locked4", {31'd0, locked4}, m_lock);
      chk("bit_err4", {31'd0, bit_err4}, m_err);
      chk("err_cnt4", {28'd0, err_cnt4}, m_ec4);
      chk("bit_cnt4", {28'd0, bit_cnt4}, m_bc4);
   endtask

   task automatic prbs(input int inj);
      step(pat[idx % 7] ^ inj, 1, 0, 0);
      idx++;
   endtask

   initial begin
      int found;
      // Reset
      step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      chk("rst_locked", {31'd0, locked}, 0);
      chk("rst_err_cnt", {16'd0, err_cnt}, 0);
      chk("rst_bit_cnt", {16'd0, bit_cnt}, 0);

      // 1: lock on bit index 10, then 70 clean counted bits
      idx = 0;
      for (int i = 0; i < 11; i++) begin
         prbs(0);
         if (i == 9)  chk("lock_early", {31'd0, locked}, 0);
         if (i == 10) chk("lock_point", {31'd0, locked}, 1);
      end
      for (int i = 0; i < 70; i++) prbs(0);
      chk("t1_bit_cnt", {16'd0, bit_cnt}, 70);
      chk("t1_err_cnt", {16'd0, err_cnt}, 0);

      // 2: single inverted bit
      prbs(1);
      chk("t2_pulse", {31'd0, bit_err}, 1);
      chk("t2_err_cnt", {16'd0, err_cnt}, 1);
      chk("t2_locked", {31'd0, locked}, 1);
      prbs(0);
      chk("t2_pulse_end", {31'd0, bit_err}, 0);
      for (int i = 0; i < 19 + 40; i++) prbs(0);
      chk("t2_no_prop", {16'd0, err_cnt}, 1);
      step(0, 0, 1, 0);

      // 3: stuck-at-0 loses lock on the 8th error, never relocks, PRBS relocks after 11 bits
      found = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 0, 0);
         if (locked == 1'b0) begin
            found = 1;
            break;
         end
      end
      chk("t3_unlock", found, 1);
      chk("t3_err_cnt", {16'd0, err_cnt}, 8);
      chk("t3_last_pulse", {31'd0, bit_err}, 1);
      for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
      chk("t3_no_relock", {31'd0, locked}, 0);
      idx = 0;
      for (int i = 0; i < 11; i++) begin
         prbs(0);
         if (i == 9)  chk("t3_relock_early", {31'd0, locked}, 0);
         if (i == 10) chk("t3_relock", {31'd0, locked}, 1);
      end

      // 4: din_valid toggling, same lock point in valid bits
      step(0, 0, 0, 1);
      idx = 0;
      for (int i = 0; i < 22; i++) begin
         if (i % 2 == 0) prbs(0);
         else step($urandom_range(0, 1), 0, 0, 0);
         if (i == 18) chk("t4_lock_early", {31'd0, locked}, 0);
         if (i == 20) chk("t4_lock_point", {31'd0, locked}, 1);
      end

      // 5: clear on the same edge as an error
      for (int i = 0; i < 10; i++) prbs(0);
      step(pat[idx % 7] ^ 1, 1, 1, 0);
      idx++;
      chk("t5_err_cnt", {16'd0, err_cnt}, 0);
      chk("t5_bit_cnt", {16'd0, bit_cnt}, 0);
      chk("t5_pulse", {31'd0, bit_err}, 1);
      for (int i = 0; i < 5; i++) prbs(0);
      prbs(1);
      chk("t5_next_err", {16'd0, err_cnt}, 1);

      // 6: saturation of the narrow counters, random valid gaps
      for (int i = 0; i < 64; i++) prbs(0);
      for (int e = 0; e < 20; e++) begin
         for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 3) == 0) step($urandom_range(0, 1), 0, 0, 0);
            prbs(0);
         end
         prbs(1);
      end
      chk("t6_sat_err4", {28'd0, err_cnt4}, 15);
      chk("t6_sat_bit4", {28'd0, bit_cnt4}, 15);
      chk("t6_err_cnt", {16'd0, err_cnt}, 21);
      chk("t6_locked", {31'd0, locked}, 1);

      // Random soak: gaps, sparse errors, occasional clears
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) step($urandom_range(0, 1), 0, $urandom_range(0, 31) == 0, 0);
         else begin
            step(pat[idx % 7] ^ ($urandom_range(0, 15) == 0), 1, $urandom_range(0, 31) == 0, 0);
            idx++;
         end
      end

      // Reset mid-operation
      for (int i = 0; i < 20; i++) prbs(0);
      step(pat[idx % 7] ^ 1, 1, 0, 1);
      chk("t6_rst_locked", {31'd0, locked}, 0);
      chk("t6_rst_bit_err", {31'd0, bit_err}, 0);
      chk("t6_rst_err_cnt", {16'd0, err_cnt}, 0);
      chk("t6_rst_bit_cnt", {16'd0, bit_cnt}, 0);
      chk("t6_rst_err4", {28'd0, err_cnt4}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
